uart_ctrl: RTL

- Controller between the CPU load/store path and the uart block.
- Buffers CPU transmit bytes in a TX FIFO and schedules one-cycle UART write ops (uart_op=2'b10) only when the uart transmitter is guaranteed idle. The uart exposes no busy flag, so the controller times each frame itself.
- Captures received bytes (uart_rvalid pulses) into an RX FIFO for CPU reads.
- Reports status (counts, full/empty, sticky overrun).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_ctrl_if.sv | 39 +++
 rtl/uart_ctrl_fifo.sv | 59 +++++
 rtl/uart_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart controller slice.
//   UART_OP_NONE / UART_OP_WRITE : encodings driven onto the uart UARTOp input
//   tx_ctrl_state_t              : transmit scheduler states
//   frame_clks()                 : clocks one 10-bit frame occupies, plus guard
package uart_pkg;

  localparam logic [1:0] UART_OP_NONE  = 2'b00;
  localparam logic [1:0] UART_OP_WRITE = 2'b10;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    WAIT      = 2'd3
  } tx_ctrl_state_t;

  // Start bit + 8 data bits + stop bit, then a few idle clocks of margin.
  function automatic int frame_clks(int clk_frequency, int baud_rate, int guard_clks);
    return 10 * (clk_frequency / baud_rate) + guard_clks;
  endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: CPU-side and uart-side signals of the uart controller.
//   CPU side : wr_en/wr_data push TX bytes, rd_en pops the RX head (rd_data),
//              tx_count/rx_count/tx_full/rx_empty/tx_busy/overrun status,
//              overrun_clr clears the sticky overrun flag.
//   uart side: uart_op/uart_wdata command the uart, uart_rdata/uart_rvalid
//              deliver received bytes.
//   slave modport = the controller, master modport = CPU plus uart model.
interface uart_ctrl_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  logic                        wr_en;
  logic [7:0]                  wr_data;
  logic                        rd_en;
  logic [7:0]                  rd_data;
  logic [$clog2(TX_DEPTH):0]   tx_count;
  logic [$clog2(RX_DEPTH):0]   rx_count;
  logic                        tx_full;
  logic                        rx_empty;
  logic                        tx_busy;
  logic                        overrun;
  logic                        overrun_clr;
  logic [1:0]                  uart_op;
  logic [7:0]                  uart_wdata;
  logic [31:0]                 uart_rdata;
  logic                        uart_rvalid;

  modport slave (
    input  wr_en, wr_data, rd_en, overrun_clr, uart_rdata, uart_rvalid,
    output rd_data, tx_count, rx_count, tx_full, rx_empty, tx_busy, overrun,
           uart_op, uart_wdata
  );

  modport master (
    output wr_en, wr_data, rd_en, overrun_clr, uart_rdata, uart_rvalid,
    input  rd_data, tx_count, rx_count, tx_full, rx_empty, tx_busy, overrun,
           uart_op, uart_wdata
  );
endinterface

// File: rtl/uart_ctrl_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read.
//   clk, rst_n : clock and asynchronous active-low reset (flushes the FIFO)
//   push/wdata : write request; accepted when not full, or when full and a
//                pop is accepted in the same cycle
//   pop        : read request; ignored when empty
//   rdata      : current head, 0 when empty
//   count/full/empty : occupancy 0..DEPTH and its flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: buffers CPU transmit bytes and schedules uart writes only when
// the uart transmitter must be idle, captures received bytes into an RX FIFO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : uart_ctrl_if.slave (CPU push/pop/status, uart command/data)
// The uart has no busy flag, so every write is followed by a full frame time
// of waiting; the same wait is applied after reset for a frame possibly
// started before it.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TX_DEPTH      = 16,
  parameter int RX_DEPTH      = 16,
  parameter int GUARD_CLKS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_ctrl_if.slave  bus
);
  localparam int FRAME_CLKS = frame_clks(CLK_FREQUENCY, BAUD_RATE, GUARD_CLKS);
  localparam int CW         = $clog2(FRAME_CLKS + 1);

  tx_ctrl_state_t state;
  logic [CW-1:0]  frame_cnt;
  logic [1:0]     uart_op_q;
  logic [7:0]     uart_wdata_q;
  logic           tx_busy_q;
  logic           overrun_q;

  logic [7:0]     tx_head;
  logic           tx_empty;
  logic           tx_pop;
  logic           rx_full;
  logic           unused_rdata_hi;

  assign tx_pop          = (state == ISSUE);
  assign unused_rdata_hi = ^bus.uart_rdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_en),
    .pop   (tx_pop),
    .wdata (bus.wr_data),
    .rdata (tx_head),
    .count (bus.tx_count),
    .full  (bus.tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.uart_rvalid),
    .pop   (bus.rd_en),
    .wdata (bus.uart_rdata[7:0]),
    .rdata (bus.rd_data),
    .count (bus.rx_count),
    .full  (rx_full),
    .empty (bus.rx_empty)
  );

  // Transmit scheduler. uart_op is registered so it is high exactly while
  // the state is ISSUE; the pop of the head happens in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT_WAIT;
      frame_cnt    <= CW'(FRAME_CLKS);
      uart_op_q    <= UART_OP_NONE;
      uart_wdata_q <= 8'h00;
      tx_busy_q    <= 1'b1;
    end else begin
      case (state)
        INIT_WAIT: begin
          if (frame_cnt == '0) begin
            state     <= IDLE;
            tx_busy_q <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt - 1'b1;
          end
        end
        IDLE: begin
          if (!tx_empty) begin
            state        <= ISSUE;
            uart_op_q    <= UART_OP_WRITE;
            uart_wdata_q <= tx_head;
            tx_busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          state     <= WAIT;
          uart_op_q <= UART_OP_NONE;
          frame_cnt <= CW'(FRAME_CLKS - 1);
        end
        WAIT: begin
          if (frame_cnt == '0) begin
            state     <= IDLE;
            tx_busy_q <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt - 1'b1;
          end
        end
        default: begin
          state     <= INIT_WAIT;
          frame_cnt <= CW'(FRAME_CLKS);
          uart_op_q <= UART_OP_NONE;
          tx_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // A drop only happens when RX is full and no read makes room; a new drop
  // outranks a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (bus.uart_rvalid && rx_full && !bus.rd_en) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.uart_op    = uart_op_q;
  assign bus.uart_wdata = uart_wdata_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.overrun    = overrun_q;

endmodule
